arb_byte_packer: RTL and testbench

- Downstream stage of the 4-channel round-robin FIFO arbiter.
- Consumes the arbiter's 8-bit dout/valid byte stream, which has no backpressure, and packs the bytes into 32-bit words.
- Buffers words in a small output queue and presents them on a valid/ready interface to the next consumer (bus writer / UART framer).
- Detects and flags drops when the consumer stalls too long.

---
 rtl/arb_byte_packer.sv | 222 ++++++++++++++++++++++
 tb/tb_arb_byte_packer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/arb_byte_packer.sv
`default_nettype none
// ============================================================================
// Module   : arb_byte_packer
// Purpose  : Packs the arbiter's 8-bit byte stream (no backpressure) into
//            32-bit words. Completed or flushed words are buffered in a small
//            circular queue and offered on a valid/ready interface. Words that
//            arrive while the queue is full (and no pop is happening) are
//            dropped, and a sticky overflow flag is raised.
//
// Ports    : clk         system clock, rising edge
//            rst         synchronous reset, active-high
//            din         byte from the arbiter
//            din_valid   byte qualifier; a byte is taken every cycle it is 1
//            flush       emit any partially assembled word now
//            dout        head word, first byte in [7:0]
//            dout_cnt    number of valid bytes in the head word (1..4)
//            dout_valid  queue non-empty
//            dout_ready  consumer accepts the head word
//            dout_par    per-lane even parity of the head word (optional)
//            overflow    sticky drop flag, cleared only by rst
//            level       queue occupancy, 0..OUT_DEPTH
//
// Options  : define ARB_BYTE_PACKER_PARITY_EN to add dout_par and the parity
//            storage in the queue.
//
// Revision : 1.0 - initial release
// ============================================================================
module arb_byte_packer #(
   parameter int OUT_DEPTH = 4,
   parameter int PTR_W     = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [7:0]       din,
   input  logic             din_valid,
   input  logic             flush,
   output logic [31:0]      dout,
   output logic [2:0]       dout_cnt,
   output logic             dout_valid,
   input  logic             dout_ready,
`ifdef ARB_BYTE_PACKER_PARITY_EN
   output logic [3:0]       dout_par,
`endif
   output logic             overflow,
   output logic [PTR_W:0]   level
);

   localparam logic [PTR_W:0]   c_full_level = OUT_DEPTH[PTR_W:0];
   localparam logic [PTR_W:0]   c_level_one  = 1;
   localparam logic [PTR_W-1:0] c_ptr_one    = 1;

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   logic [1:0]        r_idx;
   logic [31:0]       r_asm;
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [PTR_W:0]    r_level;
   logic              r_overflow;
   logic [31:0]       r_dout;
   logic [2:0]        r_dout_cnt;

   logic [31:0]       r_mem_data [OUT_DEPTH];
   logic [2:0]        r_mem_cnt  [OUT_DEPTH];

   // ------------------------------------------------------------------------
   // Combinational
   // ------------------------------------------------------------------------
   logic [31:0]       w_asm_fill;
   logic [2:0]        w_cnt_fill;
   logic              w_push;
   logic              w_pop;
   logic              w_full;
   logic              w_push_acc;
   logic              w_drop;
   logic [PTR_W:0]    w_level_next;
   logic [PTR_W-1:0]  w_rd_next;
   logic              w_head_is_new;

   // The word as it looks after this cycle's byte (if any) lands in lane idx.
   // Lanes above idx are always zero because the assembly register is cleared
   // on every push, so a partial word carries zeros in its unused lanes.
   always_comb begin
      w_asm_fill = r_asm;
      if (din_valid) begin
         w_asm_fill[{r_idx, 3'b000} +: 8] = din;
      end
   end

   assign w_cnt_fill = {1'b0, r_idx} + (din_valid ? 3'd1 : 3'd0);

   // A push happens when the fourth byte lands, or on flush whenever at least
   // one byte (held or arriving this cycle) exists.
   assign w_push = (din_valid && (r_idx == 2'd3))
                || (flush && ((r_idx != 2'd0) || din_valid));

   assign w_pop      = (r_level != '0) && dout_ready;
   assign w_full     = (r_level == c_full_level);
   // A simultaneous pop frees the slot, so a full queue can still accept.
   assign w_push_acc = w_push && (!w_full || w_pop);
   assign w_drop     = w_push && w_full && !w_pop;

   always_comb begin
      w_level_next = r_level;
      case ({w_push_acc, w_pop})
         2'b10:   w_level_next = r_level + c_level_one;
         2'b01:   w_level_next = r_level - c_level_one;
         default: w_level_next = r_level;
      endcase
   end

   assign w_rd_next = w_pop ? (r_rd_ptr + c_ptr_one) : r_rd_ptr;

   // When the only entry left after this edge is the one being written now,
   // the head register must take the incoming word directly, since the
   // storage array does not yet hold it. A word pushed into an empty queue is
   // never popped in the same cycle because w_pop requires a non-zero level.
   assign w_head_is_new = w_push_acc && (w_level_next == c_level_one);

   // ------------------------------------------------------------------------
   // Assembly, pointers, occupancy, overflow and head register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_idx      <= 2'd0;
         r_asm      <= 32'd0;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_level    <= '0;
         r_overflow <= 1'b0;
         r_dout     <= 32'd0;
         r_dout_cnt <= 3'd0;
      end else begin
         // A push restarts assembly even when the word is dropped, so the
         // next byte always begins a fresh word in lane 0.
         if (w_push) begin
            r_idx <= 2'd0;
            r_asm <= 32'd0;
         end else if (din_valid) begin
            r_idx <= r_idx + 2'd1;
            r_asm <= w_asm_fill;
         end

         if (w_push_acc) begin
            r_wr_ptr <= r_wr_ptr + c_ptr_one;
         end
         r_rd_ptr <= w_rd_next;
         r_level  <= w_level_next;

         if (w_drop) begin
            r_overflow <= 1'b1;
         end

         // Head register tracks the entry at the next read pointer. With no
         // pop it reloads the same entry, which keeps it stable while the
         // consumer stalls. When the queue drains it simply holds.
         if (w_level_next != '0) begin
            if (w_head_is_new) begin
               r_dout     <= w_asm_fill;
               r_dout_cnt <= w_cnt_fill;
            end else begin
               r_dout     <= r_mem_data[w_rd_next];
               r_dout_cnt <= r_mem_cnt[w_rd_next];
            end
         end
      end
   end

   // Queue storage carries no reset: an entry is only read after it has been
   // written, and pointers/level are reset above.
   always_ff @(posedge clk) begin
      if (w_push_acc) begin
         r_mem_data[r_wr_ptr] <= w_asm_fill;
         r_mem_cnt[r_wr_ptr]  <= w_cnt_fill;
      end
   end

`ifdef ARB_BYTE_PACKER_PARITY_EN
   // ------------------------------------------------------------------------
   // Per-lane parity, computed at push time and stored with the word
   // ------------------------------------------------------------------------
   logic [3:0] w_par_fill;
   logic [3:0] r_mem_par [OUT_DEPTH];
   logic [3:0] r_dout_par;

   for (genvar k = 0; k < 4; k++) begin : g_par
      assign w_par_fill[k] = ^w_asm_fill[8*k +: 8];
   end

   always_ff @(posedge clk) begin
      if (w_push_acc) begin
         r_mem_par[r_wr_ptr] <= w_par_fill;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_dout_par <= 4'd0;
      end else if (w_level_next != '0) begin
         if (w_head_is_new) begin
            r_dout_par <= w_par_fill;
         end else begin
            r_dout_par <= r_mem_par[w_rd_next];
         end
      end
   end

   assign dout_par = r_dout_par;
`endif

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign dout       = r_dout;
   assign dout_cnt   = r_dout_cnt;
   assign dout_valid = (r_level != '0);
   assign overflow   = r_overflow;
   assign level      = r_level;

endmodule
`default_nettype wire

// File: tb/tb_arb_byte_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_arb_byte_packer
// Purpose  : Self-checking bench for arb_byte_packer. Directed scenarios
//            followed by randomized traffic, all checked against a queue-based
//            reference model of byte packing and word buffering.
// Revision : 1.0 - initial release
// ============================================================================
module tb_arb_byte_packer;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  din;
   logic        din_valid;
   logic        flush;
   logic [31:0] dout;
   logic [2:0]  dout_cnt;
   logic        dout_valid;
   logic        dout_ready;
   logic        overflow;
   logic [2:0]  level;
`ifdef ARB_BYTE_PACKER_PARITY_EN
   logic [3:0]  dout_par;
`endif

   int n_cmp = 0;
   int n_err = 0;

   // Reference model state
   logic [31:0] m_data [$];
   int          m_cnt  [$];
   logic [7:0]  m_part [$];
   logic        m_ovf;

   always #5 clk = ~clk;

   arb_byte_packer #(
      .OUT_DEPTH (DEPTH),
      .PTR_W     (2)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .din        (din),
      .din_valid  (din_valid),
      .flush      (flush),
      .dout       (dout),
      .dout_cnt   (dout_cnt),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready),
`ifdef ARB_BYTE_PACKER_PARITY_EN
      .dout_par   (dout_par),
`endif
      .overflow   (overflow),
      .level      (level)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Model of one rising edge: bytes collect into a list; four bytes or a
   // flush with any bytes form a word; the word queue pops the head when the
   // consumer is ready and holds at most DEPTH words, dropping extras.
   task automatic model_edge();
      logic [31:0] w;
      bit          pop;
      bit          full;
      if (rst) begin
         m_data.delete();
         m_cnt.delete();
         m_part.delete();
         m_ovf = 1'b0;
         return;
      end
      pop  = (m_data.size() != 0) && dout_ready;
      full = (m_data.size() == DEPTH);
      if (din_valid) m_part.push_back(din);
      if (pop) begin
         void'(m_data.pop_front());
         void'(m_cnt.pop_front());
      end
      if (m_part.size() == 4 || (flush && m_part.size() != 0)) begin
         w = 32'd0;
         foreach (m_part[i]) w = w | (32'(m_part[i]) << (8 * i));
         if (full && !pop) begin
            m_ovf = 1'b1;
         end else begin
            m_data.push_back(w);
            m_cnt.push_back(m_part.size());
         end
         m_part.delete();
      end
   endtask

   task automatic compare_model();
      check("valid", 32'(dout_valid), 32'(m_data.size() != 0));
      check("level", 32'(level), 32'(m_data.size()));
      check("overflow", 32'(overflow), 32'(m_ovf));
      if (m_data.size() != 0) begin
         check("dout", dout, m_data[0]);
         check("dout_cnt", 32'(dout_cnt), 32'(m_cnt[0]));
`ifdef ARB_BYTE_PACKER_PARITY_EN
         begin
            logic [31:0] hw;
            logic [3:0]  par;
            hw = m_data[0];
            for (int k = 0; k < 4; k++) par[k] = ^hw[8*k +: 8];
            check("dout_par", 32'(dout_par), 32'(par));
         end
`endif
      end
   endtask

   // Drive one cycle of inputs, let the edge happen, update the model and
   // compare 1 time unit after the edge.
   task automatic step(input bit v, input logic [7:0] d, input bit f, input bit r);
      din_valid  = v;
      din        = d;
      flush      = f;
      dout_ready = r;
      @(posedge clk);
      model_edge();
      #1;
      compare_model();
   endtask

   task automatic push_word(input logic [7:0] b, input bit r);
      for (int i = 0; i < 4; i++) step(1'b1, b, 1'b0, r);
   endtask

   initial begin
      rst        = 1'b1;
      din        = 8'h00;
      din_valid  = 1'b0;
      flush      = 1'b0;
      dout_ready = 1'b0;
      m_ovf      = 1'b0;

      step(0, 8'h00, 0, 0);
      step(0, 8'h00, 0, 0);
      check("rst_dout", dout, 32'd0);
      check("rst_cnt", 32'(dout_cnt), 32'd0);
      check("rst_valid", 32'(dout_valid), 32'd0);
      check("rst_ovf", 32'(overflow), 32'd0);
      check("rst_level", 32'(level), 32'd0);
      rst = 1'b0;

      // Full word, consumer ready: visible for exactly one cycle
      step(1, 8'h11, 0, 1);
      step(1, 8'h22, 0, 1);
      step(1, 8'h33, 0, 1);
      step(1, 8'h44, 0, 1);
      check("t1_dout", dout, 32'h44332211);
      check("t1_cnt", 32'(dout_cnt), 32'd4);
      check("t1_valid", 32'(dout_valid), 32'd1);
      step(0, 8'h00, 0, 1);
      check("t1_gone", 32'(dout_valid), 32'd0);

      // Flush of a partial word, then flush with nothing held
      step(1, 8'hAA, 0, 1);
      step(1, 8'hBB, 0, 1);
      step(0, 8'h00, 1, 1);
      check("t2_dout", dout, 32'h0000BBAA);
      check("t2_cnt", 32'(dout_cnt), 32'd2);
      step(0, 8'h00, 0, 1);
      step(0, 8'h00, 1, 1);
      check("t2_noop_level", 32'(level), 32'd0);
      check("t2_noop_valid", 32'(dout_valid), 32'd0);

      // Flush together with a byte: single push including that byte
      step(1, 8'h01, 0, 1);
      step(1, 8'h02, 0, 1);
      step(1, 8'h03, 1, 1);
      check("t3_dout", dout, 32'h00030201);
      check("t3_cnt", 32'(dout_cnt), 32'd3);
      check("t3_level", 32'(level), 32'd1);
      step(0, 8'h00, 0, 1);

      // Stalled consumer: fifth word is dropped, first four drain in order
      for (int k = 1; k <= 5; k++) push_word(8'(k), 1'b0);
      check("t4_level", 32'(level), 32'd4);
      check("t4_ovf", 32'(overflow), 32'd1);
      for (int k = 1; k <= 4; k++) begin
         check("t4_drain", dout, {4{8'(k)}});
         step(0, 8'h00, 0, 1);
      end
      check("t4_empty", 32'(dout_valid), 32'd0);
      check("t4_ovf_sticky", 32'(overflow), 32'd1);

      // Full queue with simultaneous pop and push
      rst = 1'b1;
      step(0, 8'h00, 0, 0);
      rst = 1'b0;
      for (int k = 1; k <= 4; k++) push_word(8'(8'h10 + k), 1'b0);
      step(1, 8'h16, 0, 0);
      step(1, 8'h16, 0, 0);
      step(1, 8'h16, 0, 0);
      step(1, 8'h16, 0, 1);
      check("t5_level", 32'(level), 32'd4);
      check("t5_ovf", 32'(overflow), 32'd0);
      check("t5_head", dout, 32'h12121212);
      for (int i = 0; i < 5; i++) step(0, 8'h00, 0, 1);
      check("t5_empty", 32'(level), 32'd0);

      // Reset mid-operation discards everything
      for (int k = 1; k <= 3; k++) push_word(8'(8'h20 + k), 1'b0);
      step(1, 8'h55, 0, 0);
      step(1, 8'h66, 0, 0);
      check("t6_pre_level", 32'(level), 32'd3);
      rst = 1'b1;
      step(0, 8'h00, 0, 0);
      rst = 1'b0;
      check("t6_valid", 32'(dout_valid), 32'd0);
      check("t6_level", 32'(level), 32'd0);
      check("t6_ovf", 32'(overflow), 32'd0);
      step(1, 8'hA1, 0, 0);
      step(1, 8'hB2, 0, 0);
      step(1, 8'hC3, 0, 0);
      step(1, 8'hD4, 0, 0);
      check("t6_dout", dout, 32'hD4C3B2A1);
      check("t6_cnt", 32'(dout_cnt), 32'd4);

      // Randomized traffic with varying consumer throughput
      begin
         int ready_pct;
         ready_pct = 50;
         for (int c = 0; c < 4000; c++) begin
            if (c % 250 == 0) ready_pct = $urandom_range(5, 100);
            rst = ($urandom_range(0, 399) == 0);
            step($urandom_range(0, 99) < 70,
                 8'($urandom),
                 $urandom_range(0, 99) < 10,
                 $urandom_range(1, 100) <= ready_pct);
         end
         rst = 1'b0;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
